// File: rtl/axilite_param_shadow.sv
// rtl/axilite_param_shadow.sv - double-buffered parameter stage applied atomically at sample boundaries
module axilite_param_shadow #(
    parameter int                    DATA_SIZE   = 128,
    parameter logic [DATA_SIZE-1:0]  RESET_VALUE = '0,
    parameter int                    COUNT_WIDTH = 16,
    parameter int                    MAX_DEFER   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_SIZE-1:0]   regs,
    input  logic                   param_en,
    input  logic                   sample_strobe,
    input  logic                   core_busy,
    input  logic                   status_clr,
    output logic [DATA_SIZE-1:0]   active_params,
    output logic                   params_valid,
    output logic                   pending,
    output logic                   update_pulse,
    output logic [COUNT_WIDTH-1:0] update_count,
    output logic                   overrun,
    output logic                   forced
);

    localparam int DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam logic [DW-1:0] DEFER_LIMIT = DW'(MAX_DEFER);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   staging_q, staging_d;
    logic [DATA_SIZE-1:0]   active_q, active_d;
    logic [DW-1:0]          defer_q, defer_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   pulse_q, pulse_d;
    logic                   overrun_q, overrun_d;
    logic                   forced_q, forced_d;

    logic timeout;
    logic apply;

    // MAX_DEFER of zero disables the timeout path entirely
    assign timeout = (MAX_DEFER != 0) && (defer_q == DEFER_LIMIT);
    assign apply   = (state_q == S_PENDING) && !core_busy && (sample_strobe || timeout);

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        active_d  = active_q;
        defer_d   = defer_q;
        count_d   = count_q;
        valid_d   = valid_q;
        pulse_d   = apply;
        overrun_d = overrun_q;
        forced_d  = forced_q;

        if (status_clr) begin
            overrun_d = 1'b0;
            forced_d  = 1'b0;
        end

        if (apply) begin
            active_d = staging_q;
            count_d  = count_q + 1'b1;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
            if (!sample_strobe) begin
                forced_d = 1'b1;
            end
        end

        // A capture always wins the next state; old staging was already used by apply
        if (param_en) begin
            staging_d = regs;
            state_d   = S_PENDING;
            if ((state_q == S_PENDING) && !apply) begin
                overrun_d = 1'b1;
            end
        end

        if (param_en || apply || (state_q == S_IDLE)) begin
            defer_d = '0;
        end else if (defer_q != DEFER_LIMIT) begin
            defer_d = defer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            staging_q <= '0;
            active_q  <= RESET_VALUE;
            defer_q   <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
            overrun_q <= 1'b0;
            forced_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            active_q  <= active_d;
            defer_q   <= defer_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            pulse_q   <= pulse_d;
            overrun_q <= overrun_d;
            forced_q  <= forced_d;
        end
    end

    assign active_params = active_q;
    assign params_valid  = valid_q;
    assign pending       = (state_q == S_PENDING);
    assign update_pulse  = pulse_q;
    assign update_count  = count_q;
    assign overrun       = overrun_q;
    assign forced        = forced_q;

endmodule

// File: tb/tb_axilite_param_shadow.sv
// tb/tb_axilite_param_shadow.sv - randomized and directed bench for axilite_param_shadow
module tb_axilite_param_shadow;

    localparam int          DS = 128;
    localparam int          CW = 4;
    localparam int          MD = 16;
    localparam logic [DS-1:0] RV = 128'hA5A5_0F0F_5A5A_F0F0_1234_5678_9ABC_DEF0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DS-1:0] regs = '0;
    logic          param_en = 1'b0;
    logic          sample_strobe = 1'b0;
    logic          core_busy = 1'b0;
    logic          status_clr = 1'b0;
    logic [DS-1:0] active_params;
    logic          params_valid;
    logic          pending;
    logic          update_pulse;
    logic [CW-1:0] update_count;
    logic          overrun;
    logic          forced;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: behaviour stated as plain rules over an unbounded wait count
    logic [DS-1:0] m_active, m_stage;
    bit            m_pending, m_valid, m_pulse, m_overrun, m_forced;
    int            m_count, m_wait;

    axilite_param_shadow #(
        .DATA_SIZE(DS), .RESET_VALUE(RV), .COUNT_WIDTH(CW), .MAX_DEFER(MD)
    ) dut (
        .clk(clk), .rst(rst), .regs(regs), .param_en(param_en),
        .sample_strobe(sample_strobe), .core_busy(core_busy), .status_clr(status_clr),
        .active_params(active_params), .params_valid(params_valid), .pending(pending),
        .update_pulse(update_pulse), .update_count(update_count),
        .overrun(overrun), .forced(forced)
    );

    always #5 clk = ~clk;

    localparam logic [DS-1:0] A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [DS-1:0] B = 128'hBBBB_0000_BBBB_0000_CCCC_1111_DDDD_2222;

    task automatic model_reset();
        m_active = RV; m_stage = '0; m_pending = 0; m_valid = 0; m_pulse = 0;
        m_overrun = 0; m_forced = 0; m_count = 0; m_wait = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; param_en = 0; sample_strobe = 0; core_busy = 0; status_clr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [DS-1:0] r, input bit en, input bit st, input bit busy, input bit clr);
        bit fire;
        regs = r; param_en = en; sample_strobe = st; core_busy = busy; status_clr = clr;
        fire = m_pending && !busy && (st || (MD != 0 && m_wait >= MD));
        @(posedge clk); #1;
        if (clr) begin m_overrun = 0; m_forced = 0; end
        if (fire) begin
            m_active = m_stage;
            m_count  = (m_count + 1) % (1 << CW);
            m_valid  = 1;
            if (!st) m_forced = 1;
        end
        m_pulse = fire;
        if (en && m_pending && !fire) m_overrun = 1;
        if (en) begin m_stage = r; m_pending = 1; m_wait = 0; end
        else if (fire) begin m_pending = 0; m_wait = 0; end
        else if (m_pending) m_wait++;
        param_en = 0; sample_strobe = 0; core_busy = 0; status_clr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({active_params, params_valid, pending, update_pulse, update_count, overrun, forced} !==
            {RV, 1'b0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got act=%h v=%b p=%b u=%b c=%0d o=%b f=%b, need act=%h all-zero flags",
                     active_params, params_valid, pending, update_pulse, update_count, overrun, forced, RV);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 5; i++) step('0, 0, 0, 0, 0);
        step(A, 1, 1, 0, 0);
        tests_run++;
        if (pending !== 1'b1 || update_pulse !== 1'b0 || active_params !== RV) begin
            tests_failed++;
            $display("FAIL basic_capture: got p=%b u=%b act=%h, need p=1 u=0 act=%h", pending, update_pulse, active_params, RV);
        end
        step(B, 0, 0, 0, 0);
        step(B, 0, 0, 0, 0);
        step(B, 0, 1, 0, 0);
        tests_run++;
        if (active_params !== A || update_pulse !== 1'b1 || update_count !== 4'd1 ||
            params_valid !== 1'b1 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_apply: got act=%h u=%b c=%0d v=%b p=%b, need act=%h u=1 c=1 v=1 p=0",
                     active_params, update_pulse, update_count, params_valid, pending, A);
        end
        step(B, 0, 0, 0, 0);
        tests_run++;
        if (update_pulse !== 1'b0 || active_params !== A) begin
            tests_failed++;
            $display("FAIL basic_pulse_drop: got u=%b act=%h, need u=0 act=%h", update_pulse, active_params, A);
        end
    endtask

    task automatic test_isolation();
        logic [CW-1:0] c0;
        do_reset();
        step(A, 1, 0, 0, 0);
        step(B, 0, 0, 0, 0);
        step(B, 0, 1, 0, 0);
        c0 = update_count;
        tests_run++;
        if (active_params !== A || c0 !== 4'd1) begin
            tests_failed++;
            $display("FAIL isolation_apply: got act=%h c=%0d, need act=%h c=1", active_params, c0, A);
        end
        step(B, 0, 1, 0, 0);
        tests_run++;
        if (update_pulse !== 1'b0 || update_count !== 4'd1 || active_params !== A) begin
            tests_failed++;
            $display("FAIL isolation_second_strobe: got u=%b c=%0d act=%h, need u=0 c=1 act=%h",
                     update_pulse, update_count, active_params, A);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        step(A, 1, 0, 0, 0);
        step(A, 0, 0, 0, 0);
        step(B, 1, 0, 0, 0);
        step(B, 0, 1, 0, 0);
        tests_run++;
        if (active_params !== B || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set: got act=%h o=%b, need act=%h o=1", active_params, overrun, B);
        end
        step(B, 0, 0, 0, 1);
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got o=%b, need o=0", overrun);
        end
        step(A, 1, 0, 0, 0);
        step(B, 1, 0, 0, 1);
        tests_run++;
        if (overrun !== 1'b1 || pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set_wins: got o=%b p=%b, need o=1 p=1", overrun, pending);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(A, 1, 0, 0, 0);
        step(B, 1, 1, 0, 0);
        tests_run++;
        if (active_params !== A || pending !== 1'b1 || overrun !== 1'b0 || update_pulse !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_apply_capture: got act=%h p=%b o=%b u=%b, need act=%h p=1 o=0 u=1",
                     active_params, pending, overrun, update_pulse, A);
        end
        step(A, 0, 1, 0, 0);
        tests_run++;
        if (active_params !== B || update_count !== 4'd2 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_second_apply: got act=%h c=%0d p=%b, need act=%h c=2 p=0",
                     active_params, update_count, pending, B);
        end
    endtask

    task automatic test_forced();
        int n;
        bit seen;
        do_reset();
        step(A, 1, 0, 0, 0);
        step(B, 0, 1, 1, 0);
        tests_run++;
        if (update_pulse !== 1'b0 || pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_strobe_ignored: got u=%b p=%b, need u=0 p=1", update_pulse, pending);
        end
        n = 1;
        seen = 0;
        while (!seen && n < 40) begin
            step(B, 0, 0, 0, 0);
            n++;
            seen = update_pulse;
        end
        tests_run++;
        if (!seen || n != MD + 1 || forced !== 1'b1 || active_params !== A) begin
            tests_failed++;
            $display("FAIL forced_apply: got pulse=%b after %0d cycles f=%b act=%h, need pulse after %0d cycles f=1 act=%h",
                     seen, n, forced, active_params, MD + 1, A);
        end
        step(A, 1, 0, 0, 0);
        for (int i = 0; i < MD + 4; i++) step(A, 0, 0, 1, 0);
        tests_run++;
        if (pending !== 1'b1 || update_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL forced_waits_busy: got p=%b u=%b, need p=1 u=0", pending, update_pulse);
        end
        step(A, 0, 0, 0, 0);
        tests_run++;
        if (update_pulse !== 1'b1 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL forced_after_busy: got u=%b p=%b, need u=1 p=0", update_pulse, pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(A, 1, 0, 0, 0);
        step(A, 0, 1, 0, 0);
        step(B, 1, 0, 0, 0);
        do_reset();
        tests_run++;
        if (pending !== 1'b0 || active_params !== RV || update_count !== 4'd0 || params_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_pending: got p=%b act=%h c=%0d v=%b, need p=0 act=%h c=0 v=0",
                     pending, active_params, update_count, params_valid, RV);
        end
        step(A, 0, 1, 0, 0);
        tests_run++;
        if (update_pulse !== 1'b0 || active_params !== RV) begin
            tests_failed++;
            $display("FAIL reset_mid_no_apply: got u=%b act=%h, need u=0 act=%h", update_pulse, active_params, RV);
        end
    endtask

    task automatic test_back_to_back();
        bit all_pulses;
        logic [DS-1:0] v;
        do_reset();
        step(128'd1000, 1, 0, 0, 0);
        all_pulses = 1;
        for (int i = 1; i <= 17; i++) begin
            v = DS'(1000 + i);
            step(v, 1, 1, 0, 0);
            if (update_pulse !== 1'b1) all_pulses = 0;
        end
        tests_run++;
        if (!all_pulses || update_count !== 4'd1 || active_params !== DS'(1016) || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back_wrap: got pulses_ok=%b c=%0d act=%0d o=%b, need 1 c=1 act=1016 o=0",
                     all_pulses, update_count, active_params, overrun);
        end
    endtask

    task automatic test_random();
        int bad;
        logic [DS-1:0] r;
        bit en, st, busy, clr;
        bad = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r    = {$urandom, $urandom, $urandom, $urandom};
            en   = ($urandom_range(0, 5) == 0);
            st   = (i < 600) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0);
            busy = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 9) == 0);
            step(r, en, st, busy, clr);
            tests_run++;
            if ({active_params, params_valid, pending, update_pulse, update_count, overrun, forced} !==
                {m_active, m_valid, m_pending, m_pulse, CW'(m_count), m_overrun, m_forced}) begin
                tests_failed++;
                if (bad < 10)
                    $display("FAIL random_cycle_%0d: got act=%h v%b p%b u%b c%0d o%b f%b, need act=%h v%b p%b u%b c%0d o%b f%b",
                             i, active_params, params_valid, pending, update_pulse, update_count, overrun, forced,
                             m_active, m_valid, m_pending, m_pulse, m_count, m_overrun, m_forced);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_isolation();
        test_overrun();
        test_simultaneous();
        test_forced();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
